// File: rtl/tl_mem_fill_pkg.sv
// tl_mem_fill_pkg: shared FSM state type, TileLink opcodes and beat-size helper
// for the tl_mem_fill engine.
package tl_mem_fill_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam logic [2:0] TL_PUT_FULL_DATA = 3'd0;
   localparam logic [2:0] TL_ACCESS_ACK    = 3'd0;

   // log2 of the beat size in bytes, as carried in a_size
   function automatic int SizeOfBeat(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/tl_mem_fill_srcalloc.sv
// tl_mem_fill_srcalloc: in-flight source-ID bitmap with lowest-free selection.
// Flags and free_id describe the bitmap as it stands after this cycle's set/clear.
module tl_mem_fill_srcalloc
   import tl_mem_fill_pkg::*;
#(
   parameter int SourceWidth = 3
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   set_en,
   input  logic [SourceWidth-1:0] set_id,
   input  logic                   clr_en,
   input  logic [SourceWidth-1:0] clr_id,
   output logic [SourceWidth-1:0] free_id,
   output logic                   any_free,
   output logic                   all_free
);

   localparam int NumIds = 2 ** SourceWidth;

   logic [NumIds-1:0] inflight_q;
   logic [NumIds-1:0] inflight_d;
   logic [NumIds-1:0] set_mask;
   logic [NumIds-1:0] clr_mask;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en) set_mask[set_id] = 1'b1;
      if (clr_en) clr_mask[clr_id] = 1'b1;
      inflight_d = (inflight_q | set_mask) & ~clr_mask;
   end

   // The A fields are registered, so an ID freed this cycle first appears on A next cycle.
   always_comb begin
      free_id = '0;
      for (int i = NumIds - 1; i >= 0; i--) begin
         if (!inflight_d[i]) free_id = SourceWidth'(i);
      end
   end

   assign any_free = ~&inflight_d;
   assign all_free = ~|inflight_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) inflight_q <= '0;
      else       inflight_q <= inflight_d;
   end

endmodule

// File: rtl/tl_mem_fill.sv
// tl_mem_fill: TileLink-UL host that fills a region with single-beat PutFullData writes.
// Build option TL_MEM_FILL_INCR_EN: beat k carries pattern + k instead of pattern.
//
// state    | meaning
// ST_IDLE  | waiting for start_i
// ST_ISSUE | issuing PutFullData beats while source IDs are free
// ST_DRAIN | all beats accepted, waiting for outstanding AccessAcks
module tl_mem_fill
   import tl_mem_fill_pkg::*;
#(
   parameter int DataWidth   = 64,
   parameter int AddrWidth   = 38,
   parameter int SourceWidth = 3,
   parameter int LenWidth    = 24
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic                                   start_i,
   input  logic [AddrWidth-1:0]                   base_i,
   input  logic [LenWidth-1:0]                    len_i,
   input  logic [DataWidth-1:0]                   pattern_i,
   output logic                                   busy_o,
   output logic                                   done_o,
   output logic                                   error_o,
   output logic                                   host_a_valid,
   input  logic                                   host_a_ready,
   output logic [2:0]                             host_a_opcode,
   output logic [2:0]                             host_a_param,
   output logic [$clog2($clog2(DataWidth/8)+1)-1:0] host_a_size,
   output logic [SourceWidth-1:0]                 host_a_source,
   output logic [AddrWidth-1:0]                   host_a_address,
   output logic [DataWidth/8-1:0]                 host_a_mask,
   output logic                                   host_a_corrupt,
   output logic [DataWidth-1:0]                   host_a_data,
   input  logic                                   host_d_valid,
   output logic                                   host_d_ready,
   input  logic [2:0]                             host_d_opcode,
   input  logic [1:0]                             host_d_param,
   input  logic [$clog2($clog2(DataWidth/8)+1)-1:0] host_d_size,
   input  logic [SourceWidth-1:0]                 host_d_source,
   input  logic                                   host_d_sink,
   input  logic                                   host_d_denied,
   input  logic                                   host_d_corrupt,
   input  logic [DataWidth-1:0]                   host_d_data
);

   localparam int BeatBytes = DataWidth / 8;
   localparam int SizeWidth = $clog2($clog2(DataWidth/8)+1);
   localparam logic [SizeWidth-1:0] BeatSize = SizeWidth'(SizeOfBeat(DataWidth));

   state_e                state_q;
   logic [LenWidth-1:0]   remaining_q;
   logic                  a_fire;
   logic                  d_error;
   logic [SourceWidth-1:0] free_id;
   logic                  any_free;
   logic                  all_free;
   logic                  unused_d;

   assign a_fire         = host_a_valid & host_a_ready;
   assign d_error        = host_d_denied | host_d_corrupt | (host_d_opcode != TL_ACCESS_ACK);
   assign host_d_ready   = 1'b1;
   assign host_a_opcode  = TL_PUT_FULL_DATA;
   assign host_a_param   = 3'd0;
   assign host_a_corrupt = 1'b0;
   assign unused_d       = ^{host_d_param, host_d_size, host_d_sink, host_d_data};

   tl_mem_fill_srcalloc #(
      .SourceWidth (SourceWidth)
   ) u_srcalloc (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .set_en   (a_fire),
      .set_id   (host_a_source),
      .clr_en   (host_d_valid),
      .clr_id   (host_d_source),
      .free_id  (free_id),
      .any_free (any_free),
      .all_free (all_free)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= ST_IDLE;
         remaining_q    <= '0;
         busy_o         <= 1'b0;
         done_o         <= 1'b0;
         error_o        <= 1'b0;
         host_a_valid   <= 1'b0;
         host_a_size    <= '0;
         host_a_source  <= '0;
         host_a_address <= '0;
         host_a_mask    <= '0;
         host_a_data    <= '0;
      end else begin
         done_o <= 1'b0;
         // Responses seen while idle belong to a burst killed by reset.
         if (busy_o && host_d_valid && d_error) error_o <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  busy_o         <= 1'b1;
                  error_o        <= 1'b0;
                  remaining_q    <= len_i;
                  host_a_address <= base_i;
                  host_a_data    <= pattern_i;
                  host_a_size    <= BeatSize;
                  host_a_mask    <= '1;
                  host_a_source  <= free_id;
                  if (len_i == '0) begin
                     state_q <= ST_DRAIN;
                  end else begin
                     state_q      <= ST_ISSUE;
                     host_a_valid <= 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               if (a_fire) begin
                  host_a_address <= host_a_address + AddrWidth'(BeatBytes);
                  remaining_q    <= remaining_q - LenWidth'(1);
`ifdef TL_MEM_FILL_INCR_EN
                  host_a_data    <= host_a_data + DataWidth'(1);
`endif
                  if (remaining_q == LenWidth'(1)) begin
                     state_q      <= ST_DRAIN;
                     host_a_valid <= 1'b0;
                  end else begin
                     host_a_valid  <= any_free;
                     host_a_source <= free_id;
                  end
               end else if (!host_a_valid) begin
                  host_a_valid  <= any_free;
                  host_a_source <= free_id;
               end
            end
            ST_DRAIN: begin
               if (all_free) begin
                  done_o  <= 1'b1;
                  busy_o  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tl_mem_fill.sv
// tb_tl_mem_fill: directed self-checking bench for tl_mem_fill with an in-order
// AccessAck responder and an A-channel monitor.
module tb_tl_mem_fill;

   localparam int DW = 64;
   localparam int AW = 38;
   localparam int SW = 3;
   localparam int LW = 24;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          start_i = 1'b0;
   logic [AW-1:0] base_i = '0;
   logic [LW-1:0] len_i = '0;
   logic [DW-1:0] pattern_i = '0;
   logic          busy_o, done_o, error_o;
   logic          host_a_valid;
   logic          host_a_ready = 1'b1;
   logic [2:0]    host_a_opcode, host_a_param;
   logic [1:0]    host_a_size;
   logic [SW-1:0] host_a_source;
   logic [AW-1:0] host_a_address;
   logic [7:0]    host_a_mask;
   logic          host_a_corrupt;
   logic [DW-1:0] host_a_data;
   logic          host_d_valid = 1'b0;
   logic          host_d_ready;
   logic [2:0]    host_d_opcode = 3'd0;
   logic [1:0]    host_d_param = 2'd0;
   logic [1:0]    host_d_size = 2'd3;
   logic [SW-1:0] host_d_source = '0;
   logic          host_d_sink = 1'b0;
   logic          host_d_denied = 1'b0;
   logic          host_d_corrupt = 1'b0;
   logic [DW-1:0] host_d_data = '0;

   int errors = 0;
   int checks = 0;

   logic [AW-1:0] log_addr[$];
   logic [DW-1:0] log_data[$];
   logic [SW-1:0] log_src[$];
   logic [7:0]    log_mask[$];
   logic [2:0]    log_op[$];
   logic [SW-1:0] pend[$];
   int            d_count = 0;
   int            deny_at = -1;
   bit            hold_d = 1'b0;
   bit            rand_ready = 1'b0;
   bit            stall_prev = 1'b0;
   logic [AW-1:0] prev_addr;
   logic [DW-1:0] prev_data;
   logic [SW-1:0] prev_src;

   tl_mem_fill #(.DataWidth(DW), .AddrWidth(AW), .SourceWidth(SW), .LenWidth(LW)) dut (
      .clk_i (clk_i), .rst_i (rst_i), .start_i (start_i), .base_i (base_i), .len_i (len_i),
      .pattern_i (pattern_i), .busy_o (busy_o), .done_o (done_o), .error_o (error_o),
      .host_a_valid (host_a_valid), .host_a_ready (host_a_ready), .host_a_opcode (host_a_opcode),
      .host_a_param (host_a_param), .host_a_size (host_a_size), .host_a_source (host_a_source),
      .host_a_address (host_a_address), .host_a_mask (host_a_mask), .host_a_corrupt (host_a_corrupt),
      .host_a_data (host_a_data), .host_d_valid (host_d_valid), .host_d_ready (host_d_ready),
      .host_d_opcode (host_d_opcode), .host_d_param (host_d_param), .host_d_size (host_d_size),
      .host_d_source (host_d_source), .host_d_sink (host_d_sink), .host_d_denied (host_d_denied),
      .host_d_corrupt (host_d_corrupt), .host_d_data (host_d_data)
   );

   always #5 clk_i = ~clk_i;

   // Inputs for the coming posedge are driven here; outputs are stable at this edge.
   always @(negedge clk_i) begin
      if (rst_i) begin
         pend.delete();
         host_d_valid  = 1'b0;
         host_d_denied = 1'b0;
         stall_prev    = 1'b0;
      end else begin
         if (!hold_d && pend.size() > 0) begin
            host_d_valid  = 1'b1;
            host_d_source = pend.pop_front();
            host_d_denied = (d_count == deny_at);
            d_count++;
         end else begin
            host_d_valid  = 1'b0;
            host_d_denied = 1'b0;
         end
         host_a_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (stall_prev) begin
            checks++;
            if (host_a_valid !== 1'b1 || host_a_address !== prev_addr || host_a_data !== prev_data || host_a_source !== prev_src) begin
               errors++;
               $display("FAIL a_stable: valid=%0b addr=%h data=%h src=%0d, required valid=1 addr=%h data=%h src=%0d",
                        host_a_valid, host_a_address, host_a_data, host_a_source, prev_addr, prev_data, prev_src);
            end
         end
         if (host_a_valid && host_a_ready) begin
            log_addr.push_back(host_a_address);
            log_data.push_back(host_a_data);
            log_src.push_back(host_a_source);
            log_mask.push_back(host_a_mask);
            log_op.push_back(host_a_opcode);
            pend.push_back(host_a_source);
         end
         stall_prev = host_a_valid && !host_a_ready;
         prev_addr  = host_a_address;
         prev_data  = host_a_data;
         prev_src   = host_a_source;
      end
   end

   task automatic start_cmd(input logic [AW-1:0] b, input logic [LW-1:0] l, input logic [DW-1:0] p);
      @(negedge clk_i);
      base_i = b; len_i = l; pattern_i = p; start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   task automatic test_reset;
      rst_i = 1'b1;
      repeat (2) @(negedge clk_i);
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy_o); end
      checks++; if (done_o !== 1'b0 || error_o !== 1'b0) begin errors++; $display("FAIL reset_done_err: got %0b/%0b want 0/0", done_o, error_o); end
      checks++; if (host_a_valid !== 1'b0 || host_d_ready !== 1'b1) begin errors++; $display("FAIL reset_handshake: a_valid=%0b d_ready=%0b want 0/1", host_a_valid, host_d_ready); end
      checks++; if ({host_a_address, host_a_data, host_a_mask, host_a_size, host_a_source} !== '0) begin errors++; $display("FAIL reset_a_fields: addr=%h data=%h mask=%h size=%0d want all 0", host_a_address, host_a_data, host_a_mask, host_a_size); end
      rst_i = 1'b0;
      @(negedge clk_i);
      checks++; if (busy_o !== 1'b0 || host_a_valid !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%0b a_valid=%0b want 0/0", busy_o, host_a_valid); end
   endtask

   task automatic test_basic_fill;
      int b0 = log_addr.size();
      int n = 0;
      logic [DW-1:0] exp_d;
      start_cmd(38'h80_0000_00 << 4, 24'd4, 64'hA5);
      checks++; if (host_a_valid !== 1'b1 || busy_o !== 1'b1) begin errors++; $display("FAIL basic_first_valid: a_valid=%0b busy=%0b want 1/1", host_a_valid, busy_o); end
      checks++; if (host_a_size !== 2'd3 || host_a_param !== 3'd0 || host_a_corrupt !== 1'b0) begin errors++; $display("FAIL basic_fixed_fields: size=%0d param=%0d corrupt=%0b want 3/0/0", host_a_size, host_a_param, host_a_corrupt); end
      while (!done_o && n < 100) begin @(negedge clk_i); n++; end
      checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL basic_done: done not seen within %0d cycles", n); end
      checks++; if (log_addr.size() - b0 != 4) begin errors++; $display("FAIL basic_beats: got %0d want 4", log_addr.size() - b0); end
      for (int i = 0; i < 4 && b0 + i < log_addr.size(); i++) begin
`ifdef TL_MEM_FILL_INCR_EN
         exp_d = 64'hA5 + 64'(i);
`else
         exp_d = 64'hA5;
`endif
         checks++;
         if (log_addr[b0+i] !== 38'h8_0000_0000 + 38'(8*i) || log_mask[b0+i] !== 8'hFF || log_op[b0+i] !== 3'd0 || log_data[b0+i] !== exp_d) begin
            errors++;
            $display("FAIL basic_beat%0d: addr=%h mask=%h op=%0d data=%h want addr=%h mask=ff op=0 data=%h",
                     i, log_addr[b0+i], log_mask[b0+i], log_op[b0+i], log_data[b0+i], 38'h8_0000_0000 + 38'(8*i), exp_d);
         end
      end
      @(negedge clk_i);
      checks++; if (done_o !== 1'b0 || busy_o !== 1'b0 || error_o !== 1'b0) begin errors++; $display("FAIL basic_after_done: done=%0b busy=%0b err=%0b want 0/0/0", done_o, busy_o, error_o); end
   endtask

   task automatic test_source_exhaustion;
      int b0 = log_addr.size();
      int n = 0;
      hold_d = 1'b1;
      start_cmd(38'h1000, 24'd12, 64'h1111);
      repeat (20) @(negedge clk_i);
      checks++; if (log_addr.size() - b0 != 8) begin errors++; $display("FAIL exhaust_count: got %0d want 8", log_addr.size() - b0); end
      checks++; if (host_a_valid !== 1'b0) begin errors++; $display("FAIL exhaust_valid_low: got %0b want 0", host_a_valid); end
      for (int i = 0; i < 8 && b0 + i < log_src.size(); i++) begin
         checks++; if (log_src[b0+i] !== SW'(i)) begin errors++; $display("FAIL exhaust_src%0d: got %0d want %0d", i, log_src[b0+i], i); end
      end
      hold_d = 1'b0;
      while (!done_o && n < 200) begin @(negedge clk_i); n++; end
      checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL exhaust_done: done not seen within %0d cycles", n); end
      checks++; if (log_addr.size() - b0 != 12) begin errors++; $display("FAIL exhaust_total: got %0d want 12", log_addr.size() - b0); end
      for (int i = 0; i < 12 && b0 + i < log_addr.size(); i++) begin
         checks++; if (log_addr[b0+i] !== 38'h1000 + 38'(8*i)) begin errors++; $display("FAIL exhaust_addr%0d: got %h want %h", i, log_addr[b0+i], 38'h1000 + 38'(8*i)); end
      end
   endtask

   task automatic test_backpressure;
      int b0 = log_addr.size();
      int n = 0;
      rand_ready = 1'b1;
      start_cmd(38'h2000, 24'd10, 64'h1234_5678_9ABC_DEF0);
      base_i = 38'h3F_DEAD_0000; len_i = 24'd3; start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      while (!done_o && n < 400) begin @(negedge clk_i); n++; end
      rand_ready = 1'b0;
      checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL bp_done: done not seen within %0d cycles", n); end
      checks++; if (log_addr.size() - b0 != 10) begin errors++; $display("FAIL bp_count: got %0d want 10", log_addr.size() - b0); end
      for (int i = 0; i < 10 && b0 + i < log_addr.size(); i++) begin
         checks++; if (log_addr[b0+i] !== 38'h2000 + 38'(8*i)) begin errors++; $display("FAIL bp_addr%0d: got %h want %h", i, log_addr[b0+i], 38'h2000 + 38'(8*i)); end
      end
   endtask

   task automatic test_error_response;
      int n = 0;
      deny_at = d_count + 2;
      start_cmd(38'h5000, 24'd4, 64'h5A5A);
      while (!done_o && n < 100) begin @(negedge clk_i); n++; end
      checks++; if (done_o !== 1'b1 || error_o !== 1'b1) begin errors++; $display("FAIL err_at_done: done=%0b err=%0b want 1/1", done_o, error_o); end
      @(negedge clk_i);
      checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b want 1", error_o); end
      deny_at = -1;
      start_cmd(38'h5100, 24'd1, 64'h5A5A);
      checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL err_cleared: got %0b want 0", error_o); end
      n = 0;
      while (!done_o && n < 100) begin @(negedge clk_i); n++; end
      checks++; if (done_o !== 1'b1 || error_o !== 1'b0) begin errors++; $display("FAIL err_clean_run: done=%0b err=%0b want 1/0", done_o, error_o); end
   endtask

   task automatic test_zero_length;
      int b0 = log_addr.size();
      start_cmd(38'h6000, 24'd0, 64'hFFFF);
      checks++; if (done_o !== 1'b0 || busy_o !== 1'b1 || host_a_valid !== 1'b0) begin errors++; $display("FAIL zero_cycle1: done=%0b busy=%0b a_valid=%0b want 0/1/0", done_o, busy_o, host_a_valid); end
      @(negedge clk_i);
      checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL zero_cycle2_done: got %0b want 1", done_o); end
      @(negedge clk_i);
      checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL zero_cycle3: done=%0b busy=%0b want 0/0", done_o, busy_o); end
      checks++; if (log_addr.size() != b0) begin errors++; $display("FAIL zero_no_traffic: got %0d beats want 0", log_addr.size() - b0); end
   endtask

   task automatic test_reset_mid_burst;
      int b0 = log_addr.size();
      int b1;
      int n = 0;
      logic [DW-1:0] exp_d;
      hold_d = 1'b1;
      start_cmd(38'h3000, 24'd8, 64'h99);
      repeat (3) @(posedge clk_i);
      #2 rst_i = 1'b1;
      #1;
      checks++; if (busy_o !== 1'b0 || host_a_valid !== 1'b0 || done_o !== 1'b0 || error_o !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: busy=%0b a_valid=%0b done=%0b err=%0b want 0", busy_o, host_a_valid, done_o, error_o); end
      checks++; if (host_a_address !== '0 || host_a_data !== '0 || host_a_mask !== '0) begin errors++; $display("FAIL rst_mid_fields: addr=%h data=%h mask=%h want 0", host_a_address, host_a_data, host_a_mask); end
      checks++; if (log_addr.size() - b0 != 3) begin errors++; $display("FAIL rst_mid_beats: got %0d want 3", log_addr.size() - b0); end
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      hold_d = 1'b0;
      b1 = log_addr.size();
      start_cmd(38'h4000, 24'd2, 64'h77);
      while (!done_o && n < 100) begin @(negedge clk_i); n++; end
      checks++; if (done_o !== 1'b1 || error_o !== 1'b0) begin errors++; $display("FAIL rst_restart_done: done=%0b err=%0b want 1/0", done_o, error_o); end
      checks++; if (log_addr.size() - b1 != 2) begin errors++; $display("FAIL rst_restart_beats: got %0d want 2", log_addr.size() - b1); end
      for (int i = 0; i < 2 && b1 + i < log_addr.size(); i++) begin
`ifdef TL_MEM_FILL_INCR_EN
         exp_d = 64'h77 + 64'(i);
`else
         exp_d = 64'h77;
`endif
         checks++;
         if (log_addr[b1+i] !== 38'h4000 + 38'(8*i) || log_data[b1+i] !== exp_d) begin
            errors++;
            $display("FAIL rst_restart_beat%0d: addr=%h data=%h want addr=%h data=%h", i, log_addr[b1+i], log_data[b1+i], 38'h4000 + 38'(8*i), exp_d);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_fill();
      test_source_exhaustion();
      test_backpressure();
      test_error_response();
      test_zero_length();
      test_reset_mid_burst();
      repeat (2) @(negedge clk_i);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
